// File: rtl/param_sched.sv
// param_sched: double-buffered parameter frame scheduler.
// A loader writes a NUM_BYTES frame byte-by-byte into the shadow bank. A
// complete frame (pc_ready) waits in WAIT_SYNC until frame_start, when the
// banks swap and the renderer sees the new frame on its read port.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   update_reg   strobe: read_data/idx valid this cycle
//   idx          byte index of the strobe
//   read_data    byte value of the strobe
//   pc_ready     strobe: upstream frame complete
//   frame_start  strobe: safe point to swap banks
//   rd_addr      renderer read address into the active bank
//   rd_data      registered read data (0 for rd_addr >= NUM_BYTES)
//   pending      level: complete frame waiting for frame_start
//   commit       pulse, one cycle after the swap
//   seq_err      pulse, one cycle after a sequence violation
//   drop_cnt     saturating count of strobes dropped while pending
module param_sched #(
  parameter int unsigned NUM_BYTES = 55
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update_reg,
  input  logic [5:0] idx,
  input  logic [7:0] read_data,
  input  logic       pc_ready,
  input  logic       frame_start,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       pending,
  output logic       commit,
  output logic       seq_err,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_SYNC
  } state_t;

  localparam logic [6:0] NB = 7'(NUM_BYTES);

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       act_sel_q, act_sel_d;
  logic       commit_q, commit_d;
  logic       seq_err_q, seq_err_d;
  logic [7:0] drop_q, drop_d;
  logic [7:0] rd_q, rd_d;

  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       upd_abort;
  logic       idx_is_cnt;

  logic [7:0] bank0_q [NUM_BYTES];
  logic [7:0] bank1_q [NUM_BYTES];

  assign idx_is_cnt = ({1'b0, idx} == cnt_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_sel_d = act_sel_q;
    commit_d  = 1'b0;
    seq_err_d = 1'b0;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    wr_addr   = idx;
    wr_data   = read_data;
    upd_abort = 1'b0;

    case (state_q)
      IDLE: begin
        if (update_reg) begin
          if (idx == '0) begin
            wr_en   = 1'b1;
            cnt_d   = 7'd1;
            state_d = LOAD;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (update_reg) begin
          if (idx_is_cnt && (cnt_q < NB)) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 7'd1;
          end else if (idx == '0) begin
            wr_en     = 1'b1;
            cnt_d     = 7'd1;
            seq_err_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
            upd_abort = 1'b1;
          end
        end
        // A coincident pc_ready is judged against the pre-update count;
        // an update that already aborted the frame takes precedence.
        if (pc_ready && !upd_abort) begin
          if (cnt_q == NB) begin
            state_d = WAIT_SYNC;
          end else begin
            seq_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end

      WAIT_SYNC: begin
        if (update_reg && (drop_q != '1)) begin
          drop_d = drop_q + 8'd1;
        end
        if (frame_start) begin
          act_sel_d = ~act_sel_q;
          commit_d  = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Read uses the current act_sel, so a read in the swap cycle sees the old bank.
    rd_d = '0;
    if ({1'b0, rd_addr} < NB) begin
      rd_d = act_sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_sel_q <= 1'b0;
      commit_q  <= 1'b0;
      seq_err_q <= 1'b0;
      drop_q    <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_sel_q <= act_sel_d;
      commit_q  <= commit_d;
      seq_err_q <= seq_err_d;
      drop_q    <= drop_d;
      rd_q      <= rd_d;
    end
  end

  // Writes always target the bank that is not active.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (act_sel_q) begin
        bank0_q[wr_addr] <= wr_data;
      end else begin
        bank1_q[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data  = rd_q;
  assign pending  = (state_q == WAIT_SYNC);
  assign commit   = commit_q;
  assign seq_err  = seq_err_q;
  assign drop_cnt = drop_q;

endmodule
